// File: rtl/key_encoder16_pkg.sv
// -----------------------------------------------------------------------------
// key_pkg : shared types and constants for the key_encoder16 input block.
//   CODE_W      width of the encoded key index
//   key_state_e debounce state machine encoding
//   SEG_GLYPH   active-high {a,b,c,d,e,f,g} hex glyphs, indexed by code
//   seg_glyph() table lookup used when the seven-segment output is built
// -----------------------------------------------------------------------------
package key_pkg;

    localparam int CODE_W = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DEB_PRESS = 2'd1,
        PRESSED   = 2'd2,
        DEB_REL   = 2'd3
    } key_state_e;

    localparam logic [6:0] SEG_GLYPH [0:15] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    function automatic logic [6:0] seg_glyph(input logic [CODE_W-1:0] code_val);
        return SEG_GLYPH[code_val];
    endfunction

endpackage

// File: rtl/key_encoder16_if.sv
// -----------------------------------------------------------------------------
// key_encoder16_if : key-line inputs and encoded outputs of key_encoder16.
//   en             enable (low clears outputs and returns to idle)
//   key_low[15:0]  raw active-low key lines, asynchronous to clk
//   code[3:0]      index of the accepted key
//   valid          a key is currently accepted
//   press          one-cycle strobe on acceptance of a press
//   release_strobe one-cycle strobe on acceptance of a release
//                  ("release" itself is a reserved word in SystemVerilog)
//   seg[6:0]       hex glyph of code, only when KEY_SEG_OUT_EN is defined
// master = the driver of the key lines, slave = key_encoder16.
// -----------------------------------------------------------------------------
interface key_encoder16_if;
    import key_pkg::*;

    logic              en;
    logic [15:0]       key_low;
    logic [CODE_W-1:0] code;
    logic              valid;
    logic              press;
    logic              release_strobe;
`ifdef KEY_SEG_OUT_EN
    logic [6:0]        seg;
`endif

    modport master (
        output en, key_low,
        input  code, valid, press, release_strobe
`ifdef KEY_SEG_OUT_EN
        , input seg
`endif
    );

    modport slave (
        input  en, key_low,
        output code, valid, press, release_strobe
`ifdef KEY_SEG_OUT_EN
        , output seg
`endif
    );

endinterface

// File: rtl/key_encoder16_prio.sv
// -----------------------------------------------------------------------------
// key_prio16 : combinational lowest-index priority encoder, 16 -> {any, pri}.
//   act[15:0]  active-high request lines
//   any        OR of all request lines
//   pri[3:0]   lowest set index of act (0 when no line is set)
// -----------------------------------------------------------------------------
module key_prio16
    import key_pkg::*;
(
    input  logic [15:0]       act,
    output logic              any,
    output logic [CODE_W-1:0] pri
);

    // Scan from the top so the lowest set index is the last to win.
    always_comb begin
        any = |act;
        pri = {CODE_W{1'b0}};
        for (int i = 15; i >= 0; i--) begin
            pri = act[i] ? CODE_W'(i) : pri;
        end
    end

endmodule

// File: rtl/key_encoder16.sv
// -----------------------------------------------------------------------------
// key_encoder16 : debounced 16-line priority encoder.
// Synchronises active-low key lines, debounces presses and releases over
// DEB_CYC stable cycles, and reports the lowest pressed index with press /
// release strobes. Optional feature macro: KEY_SEG_OUT_EN adds a registered
// seven-segment glyph of code on bus.seg.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    key_encoder16_if.slave (en, key_low in; code, valid, press,
//          release_strobe, optional seg out)
// -----------------------------------------------------------------------------
module key_encoder16
    import key_pkg::*;
#(
    parameter int DEB_CYC = 50000
)(
    input  logic           clk,
    input  logic           rst_n,
    key_encoder16_if.slave bus
);

    localparam int              CNT_W    = $clog2(DEB_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [15:0]       sync1_r;
    logic [15:0]       act_r;
    logic [15:0]       snap_r;
    logic [CNT_W-1:0]  cnt_r;
    key_state_e        state_r;
    logic [CODE_W-1:0] code_r;
    logic              valid_r;
    logic              press_r;
    logic              release_r;
    logic              any_s;
    logic [CODE_W-1:0] pri_s;
`ifdef KEY_SEG_OUT_EN
    logic [6:0]        seg_r;
`endif

    // Two-flop synchroniser; keeps running while en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 16'h0000;
            act_r   <= 16'h0000;
        end else begin
            sync1_r <= ~bus.key_low;
            act_r   <= sync1_r;
        end
    end

    key_prio16 u_prio (
        .act (act_r),
        .any (any_s),
        .pri (pri_s)
    );

    // Debounce state machine with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            snap_r    <= 16'h0000;
            code_r    <= {CODE_W{1'b0}};
            valid_r   <= 1'b0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
`ifdef KEY_SEG_OUT_EN
            seg_r     <= 7'b0000000;
`endif
        end else if (!bus.en) begin
            state_r   <= IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            code_r    <= {CODE_W{1'b0}};
            valid_r   <= 1'b0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
`ifdef KEY_SEG_OUT_EN
            seg_r     <= 7'b0000000;
`endif
        end else begin
            press_r   <= 1'b0;
            release_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (any_s) begin
                        snap_r  <= act_r;
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= DEB_PRESS;
                    end
                end
                DEB_PRESS: begin
                    if (!any_s) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= IDLE;
                    end else if (act_r != snap_r) begin
                        // Any change of the pressed set restarts the window.
                        snap_r <= act_r;
                        cnt_r  <= {CNT_W{1'b0}};
                    end else if (cnt_r == CNT_LAST) begin
                        code_r  <= pri_s;
                        valid_r <= 1'b1;
                        press_r <= 1'b1;
                        state_r <= PRESSED;
`ifdef KEY_SEG_OUT_EN
                        seg_r   <= seg_glyph(pri_s);
`endif
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                PRESSED: begin
                    // No rollover: the accepted code holds while any key is down.
                    if (!any_s) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= DEB_REL;
                    end
                end
                DEB_REL: begin
                    if (any_s) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= PRESSED;
                    end else if (cnt_r == CNT_LAST) begin
                        valid_r   <= 1'b0;
                        release_r <= 1'b1;
                        cnt_r     <= {CNT_W{1'b0}};
                        state_r   <= IDLE;
`ifdef KEY_SEG_OUT_EN
                        seg_r     <= 7'b0000000;
`endif
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    cnt_r   <= {CNT_W{1'b0}};
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.code           = code_r;
    assign bus.valid          = valid_r;
    assign bus.press          = press_r;
    assign bus.release_strobe = release_r;
`ifdef KEY_SEG_OUT_EN
    assign bus.seg            = seg_r;
`endif

endmodule
